// File: rtl/beta_if_stage.sv
// beta_if_stage -- instruction fetch stage, first stage ahead of decode.
//
// Owns the PC and runs a req/gnt/rvalid handshake with instruction memory.
// Exactly one instruction is presented to decode at a time. Decode then either
// releases it (if_next_i, fetch PC+4) or redirects (if_jump_i). Compressed
// instructions are not supported, so the PC always advances by 4.
//
// Ports:
//   clk_i, rstn_i        clock / synchronous active-low reset
//   imem_req_o           fetch request, held until granted
//   imem_addr_o          word-aligned fetch address, stable while ungranted
//   imem_gnt_i           memory accepted the request this cycle
//   imem_rvalid_i        imem_rdata_i valid this cycle
//   imem_rdata_i         fetched instruction word
//   if_next_i            decode is done with the current instruction
//   if_jump_i            redirect request
//   if_jump_addr_i       redirect target (low two bits are dropped)
//   if_instr_o           current instruction to decode
//   if_new_instr_o       1-cycle pulse: if_instr_o was just loaded
//   if_pc_o              PC of if_instr_o
//   if_stage_busy_o      stage is inside an imem transaction (not holding)

module beta_if_stage #(
  parameter int unsigned DataWidth  = 32,
  parameter logic [31:0] BootAddr   = 32'h0000_0000,
  parameter int unsigned Compressed = 0
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  output logic                 imem_req_o,
  output logic [DataWidth-1:0] imem_addr_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [DataWidth-1:0] imem_rdata_i,
  input  logic                 if_next_i,
  input  logic                 if_jump_i,
  input  logic [DataWidth-1:0] if_jump_addr_i,
  output logic [DataWidth-1:0] if_instr_o,
  output logic                 if_new_instr_o,
  output logic [DataWidth-1:0] if_pc_o,
  output logic                 if_stage_busy_o
);

  // Only the 32-bit, uncompressed configuration is implemented.
  if (DataWidth != 32 || Compressed != 0) begin : g_bad_cfg
    $error("beta_if_stage: only DataWidth=32 and Compressed=0 are supported");
  end

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_HOLD = 2'd3;

  localparam logic [DataWidth-1:0] BootPc = {BootAddr[DataWidth-1:2], 2'b00};

  logic [1:0]           state;
  logic [DataWidth-1:0] pc;         // address of the fetch in flight / next fetch
  logic [DataWidth-1:0] pc_q;       // PC of the instruction shown to decode
  logic [DataWidth-1:0] instr_q;
  logic                 new_q;
  logic                 jmp_pend;   // redirect seen mid-transaction
  logic [DataWidth-1:0] jmp_tgt;

  logic [DataWidth-1:0] jump_al;
  logic                 unused_jump_lsb;

  assign jump_al         = {if_jump_addr_i[DataWidth-1:2], 2'b00};
  assign unused_jump_lsb = ^if_jump_addr_i[1:0];

  assign imem_req_o      = (state == S_REQ);
  assign imem_addr_o     = pc;
  assign if_instr_o      = instr_q;
  assign if_new_instr_o  = new_q;
  assign if_pc_o         = pc_q;     // reset loads BootPc, so BOOT shows BootAddr
  assign if_stage_busy_o = (state != S_HOLD);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state    <= S_BOOT;
      pc       <= BootPc;
      pc_q     <= BootPc;
      instr_q  <= '0;
      new_q    <= 1'b0;
      jmp_pend <= 1'b0;
      jmp_tgt  <= '0;
    end else begin
      new_q <= 1'b0;
      case (state)
        S_BOOT: state <= S_REQ;

        S_REQ: begin
          // The request is never retracted: a redirect here is parked and
          // the granted transaction's data is dropped when it returns.
          if (if_jump_i) begin
            jmp_pend <= 1'b1;
            jmp_tgt  <= jump_al;
          end
          if (imem_gnt_i) state <= S_WAIT;
        end

        S_WAIT: begin
          if (imem_rvalid_i) begin
            if (if_jump_i) begin
              // Same-cycle redirect wins over any older parked target.
              pc       <= jump_al;
              jmp_pend <= 1'b0;
              state    <= S_REQ;
            end else if (jmp_pend) begin
              pc       <= jmp_tgt;
              jmp_pend <= 1'b0;
              state    <= S_REQ;
            end else begin
              instr_q <= imem_rdata_i;
              pc_q    <= pc;
              new_q   <= 1'b1;
              state   <= S_HOLD;
            end
          end else if (if_jump_i) begin
            jmp_pend <= 1'b1;
            jmp_tgt  <= jump_al;
          end
        end

        S_HOLD: begin
          if (if_jump_i) begin
            pc    <= jump_al;
            state <= S_REQ;
          end else if (if_next_i) begin
            pc    <= pc + DataWidth'(4);   // wraps mod 2^32
            state <= S_REQ;
          end
        end

        default: state <= S_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_beta_if_stage.sv
module tb_beta_if_stage;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        if_next_i;
  logic        if_jump_i;
  logic [31:0] if_jump_addr_i;
  logic [31:0] if_instr_o;
  logic        if_new_instr_o;
  logic [31:0] if_pc_o;
  logic        if_stage_busy_o;

  int checks = 0;
  int errors = 0;

  beta_if_stage #(.DataWidth(32), .BootAddr(32'h0000_0000), .Compressed(0)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .if_next_i(if_next_i), .if_jump_i(if_jump_i), .if_jump_addr_i(if_jump_addr_i),
    .if_instr_o(if_instr_o), .if_new_instr_o(if_new_instr_o), .if_pc_o(if_pc_o),
    .if_stage_busy_o(if_stage_busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Instruction memory contents: 0x13 (nop) at address 0, a pattern elsewhere.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    return {a[15:0], a[31:16]} ^ 32'hC0DE_0003;
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  // Transaction-level model: what decode should see and what memory should
  // be asked for, tracked as protocol phases rather than FSM states.
  bit          m_boot, m_req, m_out, m_hold, m_pend, m_pulse;
  logic [31:0] m_req_addr, m_out_addr, m_tgt, m_pc, m_instr;

  task automatic model_reset();
    m_boot = 1; m_req = 0; m_out = 0; m_hold = 0; m_pend = 0; m_pulse = 0;
    m_req_addr = 32'h0; m_out_addr = 32'h0; m_tgt = 32'h0; m_pc = 32'h0; m_instr = 32'h0;
  endtask

  task automatic model_update(input bit j, input bit n, input logic [31:0] ja,
                              input bit g, input bit rv);
    m_pulse = 0;
    if (m_boot) begin
      m_boot = 0; m_req = 1;
    end else if (m_req) begin
      if (j) begin m_pend = 1; m_tgt = align(ja); end
      if (g) begin m_req = 0; m_out = 1; m_out_addr = m_req_addr; end
    end else if (m_out) begin
      if (rv) begin
        m_out = 0;
        if (j || m_pend) begin
          m_req_addr = j ? align(ja) : m_tgt;
          m_pend = 0; m_req = 1;
        end else begin
          m_pulse = 1; m_hold = 1; m_pc = m_out_addr; m_instr = mem_word(m_out_addr);
        end
      end else if (j) begin
        m_pend = 1; m_tgt = align(ja);
      end
    end else if (m_hold) begin
      if (j) begin
        m_req_addr = align(ja); m_hold = 0; m_req = 1;
      end else if (n) begin
        m_req_addr = m_pc + 32'd4; m_hold = 0; m_req = 1;
      end
    end
  endtask

  // One clock: drive inputs at negedge, advance at posedge, return at negedge.
  task automatic step(input bit j, input bit n, input logic [31:0] ja,
                      input bit g, input bit rv);
    if_jump_i = j; if_next_i = n; if_jump_addr_i = ja;
    imem_gnt_i = g; imem_rvalid_i = rv;
    imem_rdata_i = m_out ? mem_word(m_out_addr) : $urandom();
    @(posedge clk_i);
    model_update(j, n, ja, g, rv);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rstn_i = 0; if_jump_i = 0; if_next_i = 0; if_jump_addr_i = 0;
    imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
    @(posedge clk_i);
    model_reset();
    @(negedge clk_i);
    rstn_i = 1;
  endtask

  task automatic test_reset();
    do_reset();
    do_reset();
    checks++;
    if (imem_req_o !== 1'b0 || if_stage_busy_o !== 1'b1 || if_pc_o !== 32'h0 ||
        if_instr_o !== 32'h0 || if_new_instr_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_state req=%b busy=%b pc=%h instr=%h pulse=%b exp 0 1 00000000 00000000 0",
               imem_req_o, if_stage_busy_o, if_pc_o, if_instr_o, if_new_instr_o);
    end
  endtask

  task automatic test_boot_fetch();
    step(0, 0, 0, 1, 1);  // BOOT: gnt/rvalid ignored while no request
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0 || if_new_instr_o !== 1'b0) begin
      errors++; $display("FAIL boot_req req=%b addr=%h exp 1 00000000", imem_req_o, imem_addr_o);
    end
    step(0, 0, 0, 1, 0);
    checks++;
    if (imem_req_o !== 1'b0 || if_stage_busy_o !== 1'b1) begin
      errors++; $display("FAIL boot_wait req=%b busy=%b exp 0 1", imem_req_o, if_stage_busy_o);
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if (if_new_instr_o !== 1'b1 || if_instr_o !== 32'h13 || if_pc_o !== 32'h0 ||
        if_stage_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL boot_pulse pulse=%b instr=%h pc=%h busy=%b exp 1 00000013 00000000 0",
               if_new_instr_o, if_instr_o, if_pc_o, if_stage_busy_o);
    end
    step(0, 0, 0, 1, 1);  // holding: stray gnt/rvalid ignored
    checks++;
    if (if_new_instr_o !== 1'b0 || if_instr_o !== 32'h13 || imem_req_o !== 1'b0) begin
      errors++; $display("FAIL boot_hold pulse=%b instr=%h req=%b exp 0 00000013 0",
                         if_new_instr_o, if_instr_o, imem_req_o);
    end
  endtask

  task automatic test_next_stall();
    int pulses = 0;
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4 || if_new_instr_o !== 1'b0) begin
        errors++; $display("FAIL stall_req cyc=%0d req=%b addr=%h pulse=%b exp 1 00000004 0",
                           i, imem_req_o, imem_addr_o, if_new_instr_o);
      end
      step(0, 1, 0, 0, 1);  // no gnt yet; next and rvalid ignored here
    end
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin
      errors++; $display("FAIL stall_hold req=%b addr=%h exp 1 00000004", imem_req_o, imem_addr_o);
    end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    checks++;
    if (if_new_instr_o !== 1'b1 || if_instr_o !== mem_word(32'h4) || if_pc_o !== 32'h4) begin
      errors++; $display("FAIL next_pulse pulse=%b instr=%h pc=%h exp 1 %h 00000004",
                         if_new_instr_o, if_instr_o, if_pc_o, mem_word(32'h4));
    end
    for (int i = 0; i < 3; i++) begin
      if (if_new_instr_o === 1'b1) pulses++;
      step(0, 0, 0, 0, 0);
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL next_one_pulse pulses=%0d exp 1", pulses);
    end
  endtask

  task automatic test_jump_wait();
    step(0, 1, 0, 0, 0);          // request 0x8
    step(0, 0, 0, 1, 0);          // granted
    step(1, 0, 32'h102, 0, 0);    // redirect while waiting
    checks++;
    if (imem_req_o !== 1'b0 || if_stage_busy_o !== 1'b1 || if_new_instr_o !== 1'b0) begin
      errors++; $display("FAIL jw_wait req=%b busy=%b pulse=%b exp 0 1 0",
                         imem_req_o, if_stage_busy_o, if_new_instr_o);
    end
    step(0, 0, 0, 0, 1);          // stale data returns
    checks++;
    if (if_new_instr_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin
      errors++; $display("FAIL jw_drop pulse=%b req=%b addr=%h exp 0 1 00000100",
                         if_new_instr_o, imem_req_o, imem_addr_o);
    end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    checks++;
    if (if_new_instr_o !== 1'b1 || if_pc_o !== 32'h100 || if_instr_o !== mem_word(32'h100)) begin
      errors++; $display("FAIL jw_pulse pulse=%b pc=%h instr=%h exp 1 00000100 %h",
                         if_new_instr_o, if_pc_o, if_instr_o, mem_word(32'h100));
    end
  endtask

  task automatic test_jump_priority();
    step(1, 1, 32'h200, 0, 0);
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin
      errors++; $display("FAIL prio_addr req=%b addr=%h exp 1 00000200", imem_req_o, imem_addr_o);
    end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    checks++;
    if (if_new_instr_o !== 1'b1 || if_pc_o !== 32'h200) begin
      errors++; $display("FAIL prio_pulse pulse=%b pc=%h exp 1 00000200", if_new_instr_o, if_pc_o);
    end
  endtask

  task automatic test_wrap();
    step(1, 0, 32'hFFFF_FFFF, 0, 0);
    checks++;
    if (imem_addr_o !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_align addr=%h exp fffffffc", imem_addr_o);
    end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    checks++;
    if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      errors++; $display("FAIL wrap_next req=%b addr=%h exp 1 00000000", imem_req_o, imem_addr_o);
    end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    checks++;
    if (if_new_instr_o !== 1'b1 || if_pc_o !== 32'h0 || if_instr_o !== 32'h13) begin
      errors++; $display("FAIL wrap_pulse pulse=%b pc=%h instr=%h exp 1 00000000 00000013",
                         if_new_instr_o, if_pc_o, if_instr_o);
    end
  endtask

  task automatic test_reset_mid();
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);          // waiting for rvalid of 0x4
    do_reset();
    checks++;
    if (imem_req_o !== 1'b0 || if_stage_busy_o !== 1'b1 || if_pc_o !== 32'h0 || if_instr_o !== 32'h0) begin
      errors++; $display("FAIL rmid_state req=%b busy=%b pc=%h instr=%h exp 0 1 00000000 00000000",
                         imem_req_o, if_stage_busy_o, if_pc_o, if_instr_o);
    end
    step(0, 0, 0, 0, 1);          // late rvalid during BOOT
    step(0, 0, 0, 0, 1);          // and during REQ
    checks++;
    if (if_new_instr_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin
      errors++; $display("FAIL rmid_stray pulse=%b req=%b addr=%h exp 0 1 00000000",
                         if_new_instr_o, imem_req_o, imem_addr_o);
    end
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    checks++;
    if (if_new_instr_o !== 1'b1 || if_pc_o !== 32'h0 || if_instr_o !== 32'h13) begin
      errors++; $display("FAIL rmid_refetch pulse=%b pc=%h instr=%h exp 1 00000000 00000013",
                         if_new_instr_o, if_pc_o, if_instr_o);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 4000; c++) begin
      bit          j, n, g, rv;
      logic [31:0] ja;
      if ($urandom_range(0, 199) == 0) do_reset();
      j  = ($urandom_range(0, 99) < 6);
      n  = ($urandom_range(0, 99) < 30);
      ja = $urandom();
      g  = m_req ? ($urandom_range(0, 99) < 55) : ($urandom_range(0, 99) < 15);
      rv = m_out ? ($urandom_range(0, 99) < 45) : ($urandom_range(0, 99) < 15);
      step(j, n, ja, g, rv);
      checks++;
      if (imem_req_o !== m_req || (m_req && imem_addr_o !== m_req_addr) ||
          if_stage_busy_o !== !m_hold) begin
        errors++;
        $display("FAIL rnd_imem cyc=%0d req=%b addr=%h busy=%b exp %b %h %b",
                 c, imem_req_o, imem_addr_o, if_stage_busy_o, m_req, m_req_addr, !m_hold);
      end
      checks++;
      if (if_new_instr_o !== m_pulse || if_instr_o !== m_instr || if_pc_o !== m_pc) begin
        errors++;
        $display("FAIL rnd_decode cyc=%0d pulse=%b instr=%h pc=%h exp %b %h %h",
                 c, if_new_instr_o, if_instr_o, if_pc_o, m_pulse, m_instr, m_pc);
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clk_i);
    test_reset();
    test_boot_fetch();
    test_next_stall();
    test_jump_wait();
    test_jump_priority();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
